// File: rtl/shreg_pkg.sv
// ============================================================================
//  Module      : shreg_pkg
//  Description : Mode and state encodings shared by the shreg_pe_sr block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shreg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROTL = 3'b100;
    localparam logic [2:0] MODE_ROTR = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage : shreg_pkg

`default_nettype wire

// File: rtl/shreg_pe_sr.sv
// ============================================================================
//  Module      : shreg_pe_sr
//  Description : Parallel-load shift/rotate register with an automatic
//                MSB-first serializer (load + WIDTH shifts, done pulse).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shreg_pe_sr
    import shreg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             so_msb,
    output logic             so_lsb,
    output logic             busy,
    output logic             done
);

    localparam int                 c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    logic [WIDTH-1:0]   r_q;
    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_done;
    logic [WIDTH-1:0]   w_manual_q;

    // Next value for manual operation while idle; reserved codes hold.
    always_comb begin
        w_manual_q = r_q;
        case (mode)
            MODE_HOLD: w_manual_q = r_q;
            MODE_LOAD: w_manual_q = d;
            MODE_SHL:  w_manual_q = {r_q[WIDTH-2:0], sin};
            MODE_SHR:  w_manual_q = {sin, r_q[WIDTH-1:1]};
            MODE_ROTL: w_manual_q = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            MODE_ROTR: w_manual_q = {r_q[0], r_q[WIDTH-1:1]};
            default:   w_manual_q = r_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q     <= RST_VAL;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else if (en) begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_q     <= d;
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_q <= w_manual_q;
                    end
                end
                ST_SHIFT: begin
                    r_q   <= {r_q[WIDTH-2:0], sin};
                    r_cnt <= r_cnt + 1'b1;
                    // Counter holds the shifts already done; this edge is shift WIDTH.
                    if (r_cnt == c_last) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign q      = r_q;
    assign so_msb = r_q[WIDTH-1];
    assign so_lsb = r_q[0];
    assign busy   = (r_state == ST_SHIFT);
    assign done   = r_done;

endmodule : shreg_pe_sr

`default_nettype wire

// File: tb/tb_shreg_pe_sr.sv
// ============================================================================
//  Module      : tb_shreg_pe_sr
//  Description : Directed self-checking bench for shreg_pe_sr (WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shreg_pe_sr;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [2:0] mode = 3'b000;
    logic       start = 1'b0;
    logic [7:0] d = 8'h00;
    logic       sin = 1'b0;

    logic [7:0] q0, q1;
    logic       so_msb0, so_lsb0, busy0, done0;
    logic       so_msb1, so_lsb1, busy1, done1;

    int n_checks = 0;
    int n_fail   = 0;

    shreg_pe_sr #(.WIDTH(8), .RST_VAL(8'h00)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .start(start), .d(d), .sin(sin),
        .q(q0), .so_msb(so_msb0), .so_lsb(so_lsb0), .busy(busy0), .done(done0)
    );

    shreg_pe_sr #(.WIDTH(8), .RST_VAL(8'h3C)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .start(start), .d(d), .sin(sin),
        .q(q1), .so_msb(so_msb1), .so_lsb(so_lsb1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode = 3'b001; d = 8'hA5; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; mode = 3'b000;
        n_checks++;
        if (q0 !== 8'h00) begin n_fail++; $display("FAIL reset_q got %h exp 00", q0); end
        n_checks++;
        if (q1 !== 8'h3C) begin n_fail++; $display("FAIL reset_q_rstval got %h exp 3c", q1); end
        n_checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || busy1 !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got busy=%b done=%b exp 0 0", busy0, done0);
        end
    endtask

    task automatic test_manual();
        logic [2:0] modes [6];
        logic       sins  [6];
        logic [7:0] exps  [6];
        modes = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b100, 3'b110};
        sins  = '{1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b1};
        exps  = '{8'hA5,  8'h4B,  8'hA5,  8'hD2,  8'hA5,  8'hA5};
        en = 1'b1; d = 8'hA5;
        for (int i = 0; i < 6; i++) begin
            mode = modes[i]; sin = sins[i];
            tick();
            n_checks++;
            if (q0 !== exps[i]) begin
                n_fail++; $display("FAIL manual_mode%0d got %h exp %h", i, q0, exps[i]);
            end
            n_checks++;
            if (so_msb0 !== exps[i][7] || so_lsb0 !== exps[i][0]) begin
                n_fail++; $display("FAIL manual_so%0d got msb=%b lsb=%b exp %b %b",
                                   i, so_msb0, so_lsb0, exps[i][7], exps[i][0]);
            end
        end
        mode = 3'b000;
    endtask

    task automatic test_enable();
        en = 1'b1; mode = 3'b001; d = 8'hA5;
        tick();
        en = 1'b0; d = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (q0 !== 8'hA5) begin n_fail++; $display("FAIL enable_hold%0d got %h exp a5", i, q0); end
        end
        en = 1'b1; mode = 3'b000;
    endtask

    task automatic test_serialize();
        logic [7:0] pat;
        int         busy_cnt;
        pat = 8'hC3; busy_cnt = 0;
        en = 1'b1; sin = 1'b0; d = pat; start = 1'b1; mode = 3'b100;
        tick();
        start = 1'b0; mode = 3'b000;
        n_checks++;
        if (q0 !== 8'hC3) begin n_fail++; $display("FAIL ser_load got %h exp c3", q0); end
        for (int k = 0; k < 8; k++) begin
            if (busy0 === 1'b1) busy_cnt++;
            n_checks++;
            if (so_msb0 !== pat[7-k] || done0 !== 1'b0) begin
                n_fail++; $display("FAIL ser_bit%0d got so=%b done=%b exp %b 0", k, so_msb0, done0, pat[7-k]);
            end
            start = (k == 2 || k == 3); d = 8'hFF;
            tick();
            start = 1'b0;
        end
        n_checks++;
        if (busy_cnt != 8) begin n_fail++; $display("FAIL ser_busy_len got %0d exp 8", busy_cnt); end
        n_checks++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || q0 !== 8'h00) begin
            n_fail++; $display("FAIL ser_end got done=%b busy=%b q=%h exp 1 0 00", done0, busy0, q0);
        end
        tick();
        n_checks++;
        if (done0 !== 1'b0 || busy0 !== 1'b0) begin
            n_fail++; $display("FAIL ser_after got done=%b busy=%b exp 0 0", done0, busy0);
        end
    endtask

    task automatic test_stall_abort();
        logic [7:0] pat;
        int         busy_cnt;
        pat = 8'hC3; busy_cnt = 0;
        en = 1'b1; sin = 1'b0; d = pat; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (busy0 === 1'b1) busy_cnt++;
            n_checks++;
            if (so_msb0 !== pat[7-k]) begin
                n_fail++; $display("FAIL stall_bit%0d got %b exp %b", k, so_msb0, pat[7-k]);
            end
            if (k == 1) begin
                en = 1'b0;
                for (int g = 0; g < 3; g++) begin
                    tick();
                    if (busy0 === 1'b1) busy_cnt++;
                    n_checks++;
                    if (so_msb0 !== pat[6]) begin
                        n_fail++; $display("FAIL stall_hold%0d got %b exp %b", g, so_msb0, pat[6]);
                    end
                end
                en = 1'b1;
            end
            tick();
        end
        n_checks++;
        if (busy_cnt != 11) begin n_fail++; $display("FAIL stall_busy_len got %0d exp 11", busy_cnt); end
        en = 1'b0;
        tick();
        n_checks++;
        if (done0 !== 1'b1) begin n_fail++; $display("FAIL stall_done_hold got %b exp 1", done0); end
        en = 1'b1;
        tick();
        n_checks++;
        if (done0 !== 1'b0) begin n_fail++; $display("FAIL stall_done_clear got %b exp 0", done0); end

        d = pat; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (busy0 !== 1'b0 || q0 !== 8'h00 || done0 !== 1'b0) begin
            n_fail++; $display("FAIL abort got busy=%b q=%h done=%b exp 0 00 0", busy0, q0, done0);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            n_checks++;
            if (done0 !== 1'b0 || busy0 !== 1'b0) begin
                n_fail++; $display("FAIL abort_quiet%0d got done=%b busy=%b exp 0 0", k, done0, busy0);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat;
        int         guard;
        en = 1'b1; sin = 1'b0; d = 8'hC3; start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (done0 !== 1'b1 && guard < 20) begin tick(); guard++; end
        n_checks++;
        if (done0 !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done got %b exp 1", done0); end
        pat = 8'h81; d = pat; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (busy0 !== 1'b1 || so_msb0 !== pat[7-k]) begin
                n_fail++; $display("FAIL b2b_bit%0d got busy=%b so=%b exp 1 %b", k, busy0, so_msb0, pat[7-k]);
            end
            tick();
        end
        n_checks++;
        if (done0 !== 1'b1 || busy0 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_second_done got done=%b busy=%b exp 1 0", done0, busy0);
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_enable();
        test_serialize();
        test_stall_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_shreg_pe_sr

`default_nettype wire
